// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: ID/EX control-bundle layout, ALU op codes and link register.
package id_ex_stage_pkg;

  localparam int CTRL_W = 15;
  localparam int REG_W  = 5;

  localparam int CTRL_ALUOP_HI = 14;
  localparam int CTRL_ALUOP_LO = 11;
  localparam int CTRL_REGDST   = 10;
  localparam int CTRL_BRANCH   = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BNE      = 3;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_JAL      = 1;
  localparam int CTRL_JR       = 0;

  localparam logic [REG_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hC
  } alu_op_e;

  // rt is a true source operand only for R-type, branches and stores.
  function automatic logic ctrl_use_rt(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGDST] | ctrl[CTRL_BRANCH] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources in ID.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_wreg,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rt,
  output logic             o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_wreg == i_id_rs);
  assign w_rt_match = i_id_use_rt & (i_ex_wreg == i_id_rt);

  // $zero is never a real dependency.
  assign o_hazard = i_ex_valid & i_ex_mem_read & (i_ex_wreg != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold and saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  input  logic [REG_W-1:0]  id_rd_i,
  input  logic [REG_W-1:0]  id_shamt_i,
  input  logic              id_pred_taken_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_W-1:0]  ex_rs_o,
  output logic [REG_W-1:0]  ex_rt_o,
  output logic [REG_W-1:0]  ex_wreg_o,
  output logic [REG_W-1:0]  ex_shamt_o,
  output logic              ex_pred_taken_o,
  output logic              ex_valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_wreg;
  logic [REG_W-1:0]  r_shamt;
  logic              r_pred_taken;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_hazard;
  logic [REG_W-1:0]  w_wreg_next;
  logic [CNT_W-1:0]  w_bubble_cnt_inc;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl[CTRL_MEMREAD]),
    .i_ex_wreg     (r_wreg),
    .i_id_rs       (id_rs_i),
    .i_id_rt       (id_rt_i),
    .i_id_use_rt   (ctrl_use_rt(id_ctrl_i)),
    .o_hazard      (w_hazard)
  );

  assign stall_o = w_hazard & ~flush_i & ~hold_i;

  always_comb begin
    w_wreg_next = id_rt_i;
    if (id_ctrl_i[CTRL_JAL]) begin
      w_wreg_next = LINK_REG;
    end else if (id_ctrl_i[CTRL_REGDST]) begin
      w_wreg_next = id_rd_i;
    end
  end

  assign w_bubble_cnt_inc = (&r_bubble_cnt) ? r_bubble_cnt
                                            : r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Flush outranks hold so a mispredicted instruction cannot survive a freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl       <= '0;
      r_pc4        <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wreg       <= '0;
      r_shamt      <= '0;
      r_pred_taken <= 1'b0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush_i || (!hold_i && w_hazard)) begin
      r_ctrl       <= '0;
      r_pred_taken <= 1'b0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= w_bubble_cnt_inc;
    end else if (!hold_i) begin
      r_ctrl       <= id_ctrl_i;
      r_pc4        <= id_pc4_i;
      r_rs_data    <= id_rs_data_i;
      r_rt_data    <= id_rt_data_i;
      r_imm        <= id_imm_i;
      r_rs         <= id_rs_i;
      r_rt         <= id_rt_i;
      r_wreg       <= w_wreg_next;
      r_shamt      <= id_shamt_i;
      r_pred_taken <= id_pred_taken_i;
      r_valid      <= 1'b1;
    end
  end

  assign ex_ctrl_o       = r_ctrl;
  assign ex_pc4_o        = r_pc4;
  assign ex_rs_data_o    = r_rs_data;
  assign ex_rt_data_o    = r_rt_data;
  assign ex_imm_o        = r_imm;
  assign ex_rs_o         = r_rs;
  assign ex_rt_o         = r_rt;
  assign ex_wreg_o       = r_wreg;
  assign ex_shamt_o      = r_shamt;
  assign ex_pred_taken_o = r_pred_taken;
  assign ex_valid_o      = r_valid;
  assign bubble_cnt_o    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubbles, flush/hold priority, counter saturation, reset.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // {ALUOp,RegDst,Branch,MemRd,MemtoReg,MemWr,RegWr,ALUSrc,bne,jump,jal,jr}
  localparam logic [14:0] C_LW   = 15'b0010_0_0_1_1_0_1_1_0_0_0_0;
  localparam logic [14:0] C_ADD  = 15'b0010_1_0_0_0_0_1_0_0_0_0_0;
  localparam logic [14:0] C_ADDI = 15'b0010_0_0_0_0_0_1_1_0_0_0_0;
  localparam logic [14:0] C_SW   = 15'b0010_0_0_0_0_1_0_1_0_0_0_0;
  localparam logic [14:0] C_JAL  = 15'b0000_0_0_0_0_0_1_0_0_1_1_0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [14:0]       id_ctrl_i;
  logic [DATA_W-1:0] id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]        id_rs_i, id_rt_i, id_rd_i, id_shamt_i;
  logic              id_pred_taken_i, flush_i, hold_i;
  logic              stall_o;
  logic [14:0]       ex_ctrl_o;
  logic [DATA_W-1:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]        ex_rs_o, ex_rt_o, ex_wreg_o, ex_shamt_o;
  logic              ex_pred_taken_o, ex_valid_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_ctrl_i       (id_ctrl_i),
    .id_pc4_i        (id_pc4_i),
    .id_rs_data_i    (id_rs_data_i),
    .id_rt_data_i    (id_rt_data_i),
    .id_imm_i        (id_imm_i),
    .id_rs_i         (id_rs_i),
    .id_rt_i         (id_rt_i),
    .id_rd_i         (id_rd_i),
    .id_shamt_i      (id_shamt_i),
    .id_pred_taken_i (id_pred_taken_i),
    .flush_i         (flush_i),
    .hold_i          (hold_i),
    .stall_o         (stall_o),
    .ex_ctrl_o       (ex_ctrl_o),
    .ex_pc4_o        (ex_pc4_o),
    .ex_rs_data_o    (ex_rs_data_o),
    .ex_rt_data_o    (ex_rt_data_o),
    .ex_imm_o        (ex_imm_o),
    .ex_rs_o         (ex_rs_o),
    .ex_rt_o         (ex_rt_o),
    .ex_wreg_o       (ex_wreg_o),
    .ex_shamt_o      (ex_shamt_o),
    .ex_pred_taken_o (ex_pred_taken_o),
    .ex_valid_o      (ex_valid_o),
    .bubble_cnt_o    (bubble_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [14:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] pc4);
    id_ctrl_i       = ctrl;
    id_rs_i         = rs;
    id_rt_i         = rt;
    id_rd_i         = rd;
    id_pc4_i        = pc4;
    id_rs_data_i    = pc4 ^ 32'hA5A5_0000;
    id_rt_data_i    = pc4 ^ 32'h0000_5A5A;
    id_imm_i        = {27'd0, rd} + 32'd100;
    id_shamt_i      = rd ^ 5'd3;
    id_pred_taken_i = pc4[2];
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b1;
    set_id(C_LW, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEC);
    tick(); tick();
    chk("rst_ctrl",  32'(ex_ctrl_o), 32'h0);
    chk("rst_valid", 32'(ex_valid_o), 32'h0);
    chk("rst_cnt",   32'(bubble_cnt_o), 32'h0);
    chk("rst_pc4",   ex_pc4_o, 32'h0);
    chk("rst_wreg",  32'(ex_wreg_o), 32'h0);
    rst_n = 1'b1; hold_i = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_o), 32'h0);

    // lw $t0 then dependent add
    set_id(C_LW, 5'd2, 5'd8, 5'd0, 32'h0000_1004);
    tick();
    chk("lw_valid", 32'(ex_valid_o), 32'h1);
    chk("lw_ctrl",  32'(ex_ctrl_o), 32'(C_LW));
    chk("lw_wreg",  32'(ex_wreg_o), 32'd8);
    chk("lw_pc4",   ex_pc4_o, 32'h0000_1004);
    chk("lw_rs",    32'(ex_rs_o), 32'd2);
    chk("lw_imm",   ex_imm_o, 32'd100);
    chk("lw_pred",  32'(ex_pred_taken_o), 32'h1);
    set_id(C_ADD, 5'd8, 5'd9, 5'd10, 32'h0000_1008);
    chk("lu_stall", 32'(stall_o), 32'h1);
    tick();
    chk("bub_ctrl",  32'(ex_ctrl_o), 32'h0);
    chk("bub_valid", 32'(ex_valid_o), 32'h0);
    chk("bub_cnt",   32'(bubble_cnt_o), 32'd1);
    chk("bub_stall", 32'(stall_o), 32'h0);
    tick();
    chk("add_valid", 32'(ex_valid_o), 32'h1);
    chk("add_ctrl",  32'(ex_ctrl_o), 32'(C_ADD));
    chk("add_wreg",  32'(ex_wreg_o), 32'd10);
    chk("add_rsd",   ex_rs_data_o, 32'hA5A5_1008);
    chk("add_rtd",   ex_rt_data_o, 32'h0000_4A52);
    chk("add_shamt", 32'(ex_shamt_o), 32'd9);
    chk("add_cnt",   32'(bubble_cnt_o), 32'd1);

    // lw to $zero never stalls
    set_id(C_LW, 5'd1, 5'd0, 5'd0, 32'h0000_2000);
    tick();
    set_id(C_ADD, 5'd0, 5'd0, 5'd11, 32'h0000_2004);
    chk("zero_stall", 32'(stall_o), 32'h0);
    tick();
    chk("zero_valid", 32'(ex_valid_o), 32'h1);
    chk("zero_cnt",   32'(bubble_cnt_o), 32'd1);

    // rt only counts when used
    set_id(C_LW, 5'd1, 5'd9, 5'd0, 32'h0000_3000);
    tick();
    set_id(C_ADDI, 5'd3, 5'd9, 5'd0, 32'h0000_3004);
    chk("addi_stall", 32'(stall_o), 32'h0);
    set_id(C_SW, 5'd3, 5'd9, 5'd0, 32'h0000_3004);
    chk("sw_stall", 32'(stall_o), 32'h1);
    flush_i = 1'b1; hold_i = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_o), 32'h0);
    tick();
    chk("flush_valid", 32'(ex_valid_o), 32'h0);
    chk("flush_ctrl",  32'(ex_ctrl_o), 32'h0);
    chk("flush_cnt",   32'(bubble_cnt_o), 32'd2);
    flush_i = 1'b0; hold_i = 1'b0;

    // write-destination selection and hold
    set_id(C_JAL, 5'd0, 5'd7, 5'd5, 32'h0000_4000);
    tick();
    chk("jal_wreg", 32'(ex_wreg_o), 32'd31);
    chk("jal_ctrl", 32'(ex_ctrl_o), 32'(C_JAL));
    set_id(C_ADD, 5'd1, 5'd7, 5'd5, 32'h0000_4004);
    tick();
    chk("rtype_wreg", 32'(ex_wreg_o), 32'd5);
    hold_i = 1'b1;
    set_id(C_SW, 5'd6, 5'd12, 5'd13, 32'h0000_5000);
    tick(); tick(); tick();
    chk("hold_wreg",  32'(ex_wreg_o), 32'd5);
    chk("hold_ctrl",  32'(ex_ctrl_o), 32'(C_ADD));
    chk("hold_pc4",   ex_pc4_o, 32'h0000_4004);
    chk("hold_rt",    32'(ex_rt_o), 32'd7);
    chk("hold_valid", 32'(ex_valid_o), 32'h1);
    chk("hold_cnt",   32'(bubble_cnt_o), 32'd2);
    hold_i = 1'b0;

    // drive counter to all-ones, then one more bubble
    flush_i = 1'b1;
    for (int i = 0; i < 65533; i++) tick();
    chk("sat_reach", 32'(bubble_cnt_o), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(bubble_cnt_o), 32'h0000_FFFF);
    flush_i = 1'b0;
    set_id(C_LW, 5'd1, 5'd8, 5'd0, 32'h0000_6000);
    tick();
    set_id(C_ADD, 5'd8, 5'd2, 5'd3, 32'h0000_6004);
    tick();
    chk("sat_lu_cnt", 32'(bubble_cnt_o), 32'h0000_FFFF);
    chk("sat_lu_valid", 32'(ex_valid_o), 32'h0);

    // reset overrides hold and pending hazard
    set_id(C_LW, 5'd1, 5'd8, 5'd0, 32'h0000_7000);
    tick();
    set_id(C_ADD, 5'd8, 5'd2, 5'd3, 32'h0000_7004);
    rst_n = 1'b0; hold_i = 1'b1;
    tick();
    chk("rst2_cnt",   32'(bubble_cnt_o), 32'h0);
    chk("rst2_ctrl",  32'(ex_ctrl_o), 32'h0);
    chk("rst2_valid", 32'(ex_valid_o), 32'h0);
    chk("rst2_pc4",   ex_pc4_o, 32'h0);
    chk("rst2_wreg",  32'(ex_wreg_o), 32'h0);
    chk("rst2_pred",  32'(ex_pred_taken_o), 32'h0);
    chk("rst2_stall", 32'(stall_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, datapath width; CNT_W, 16, bubble counter width.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 id_ctrl_i  input  15  decode control bundle {ALUOp[3:0],RegDst,Branch,MemReadEn,MemtoReg,MemWriteEn,RegWriteEn,ALUSrc,bne,jump,jal,jr}, MSB first.
REQ-005 id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i  input  DATA_W each  PC+4, register-file reads, sign-extended immediate.
REQ-006 id_rs_i, id_rt_i, id_rd_i, id_shamt_i  input  5 each  instruction fields.
REQ-007 id_pred_taken_i  input  1  branch-predictor decision for the decoded instruction.
REQ-008 flush_i  input  1  EX-resolved mispredict/redirect; kill instruction entering EX.
REQ-009 hold_i  input  1  global pipeline freeze (e.g. memory wait).
REQ-010 stall_o  output  1  load-use stall request to PC and IF/ID.
REQ-011 ex_ctrl_o  output  15  registered control bundle, same bit order as id_ctrl_i.
REQ-012 ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  output  DATA_W each  registered data.
REQ-013 ex_rs_o, ex_rt_o, ex_wreg_o, ex_shamt_o  output  5 each  registered source regs, write destination, shift amount.
REQ-014 ex_pred_taken_o, ex_valid_o  output  1 each  registered prediction; EX holds a real instruction.
REQ-015 bubble_cnt_o  output  CNT_W  count of bubbles inserted.

Function
REQ-016 Per-edge priority SHALL be: reset > flush_i > hold_i > load-use bubble > normal capture.
REQ-017 Normal capture SHALL register all id_* inputs into ex_* outputs with 1-cycle latency and set ex_valid_o=1.
REQ-018 ex_wreg_o SHALL be captured as 31 when jal=1, else id_rd_i when RegDst=1, else id_rt_i.
REQ-019 Load-use hazard (combinational) SHALL be: ex_valid_o & ex_ctrl_o.MemReadEn & ex_wreg_o!=0 & (ex_wreg_o==id_rs_i | (use_rt & ex_wreg_o==id_rt_i)), use_rt = RegDst|Branch|MemWriteEn of id_ctrl_i.
REQ-020 stall_o SHALL equal hazard & ~flush_i & ~hold_i.
REQ-021 On load-use bubble the stage SHALL zero ex_ctrl_o, clear ex_valid_o, keep data fields don't-care, and increment bubble_cnt_o.
REQ-022 On flush_i the stage SHALL zero ex_ctrl_o, clear ex_valid_o and increment bubble_cnt_o, regardless of hold_i or hazard.
REQ-023 On hold_i (no flush) all ex_* registers and bubble_cnt_o SHALL keep their values.
REQ-024 bubble_cnt_o SHALL saturate at all-ones, never wrap.
REQ-025 A bubble SHALL last exactly one cycle per hazard; the re-presented instruction is captured normally on the following edge.

Reset
REQ-026 While rst_n=0 at a clock edge all registers SHALL clear: ex_ctrl_o=0, data/field outputs=0, ex_valid_o=0, ex_pred_taken_o=0, bubble_cnt_o=0.
REQ-027 stall_o SHALL be 0 in the cycle after reset, since ex_valid_o=0.
REQ-028 Reset mid-hold or mid-stall SHALL override both; no partial state survives.

Structure
REQ-029 Control-bundle bit positions, width 15, ALUOp encodings and link register 31 SHALL live in the shared pipeline package.
REQ-030 Hazard comparison SHALL be one combinational sub-module, load_use_detect; the rest stays in id_ex_stage.

Verification
REQ-031 lw $t0 (wreg=8) in EX, add with rs=8 in ID -> stall_o=1, next edge ex_ctrl_o=0, ex_valid_o=0, bubble_cnt_o=1; following edge add captured.
REQ-032 lw wreg=0 in EX, ID rs=0 -> stall_o=0, no bubble.
REQ-033 lw wreg=9 in EX, addi with rt=9 (use_rt=0) -> stall_o=0; same with sw rt=9 -> stall_o=1.
REQ-034 flush_i=1 with hold_i=1 and hazard present -> stall_o=0, ex_valid_o=0 next cycle, counter +1.
REQ-035 jal in ID (rd=5, rt=7) -> ex_wreg_o=31; R-type rd=5 -> 5; hold_i=1 for 3 cycles -> outputs unchanged.
REQ-036 Preload bubble_cnt_o=16'hFFFF via repeated bubbles -> one more bubble leaves 16'hFFFF; rst_n=0 -> all outputs 0.
